secure_config_regfile: RTL

SECURE_CONFIG_REGFILE -- requirements
Module: secure_config_regfile

---
 rtl/secure_config_regfile.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/secure_config_regfile.sv
`default_nettype none
// ============================================================================
// Module   : secure_config_regfile
// Purpose  : Privilege-checked configuration register file with sticky
//            per-register write locks, a protected key register (index 0),
//            a violation counter and a two-step debug unlock window.
//            One request is accepted at a time; its response is held until
//            the consumer takes it (valid/ready on both sides).
// Ports    : clk, reset          - clock, synchronous active-high reset
//            req_valid/req_ready - request handshake
//            req_write           - 1 = write, 0 = read
//            req_addr/req_wdata  - request address / write data
//            req_priv            - 0 user, 1 supervisor, 2 machine, 3 debug
//            rsp_valid/rsp_ready - response handshake
//            rsp_rdata/rsp_err   - response data / error flag
//            lock_status         - sticky write-lock bit per register
//            violation_count     - saturating count of denied accesses
//            debug_open          - debug unlock window active
// Options  : SCR_ZEROIZE_EN - when defined, the fourth violation clears the
//            key, locks it and forces the unlock FSM back to idle.
// Revision : 1.0 - initial release
// ============================================================================
module secure_config_regfile #(
    parameter int                DATA_W         = 32,
    parameter int                NUM_REGS       = 8,
    parameter int                ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 8'h10,
    parameter logic [DATA_W-1:0] KEY_INIT       = 32'hDEADBEEF,
    parameter int                UNLOCK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_priv,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [NUM_REGS-1:0] lock_status,
    output logic [7:0]          violation_count,
    output logic                debug_open
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0]        c_IDLE      = 2'd0;
    localparam logic [1:0]        c_ARMED     = 2'd1;
    localparam logic [1:0]        c_OPEN      = 2'd2;
    localparam logic [DATA_W-1:0] c_ARM_CODE  = DATA_W'(32'hC0DE0001);
    localparam logic [DATA_W-1:0] c_OPEN_CODE = DATA_W'(32'hC0DE0002);
    localparam logic [15:0]       c_TMR_LOAD  = 16'(UNLOCK_TIMEOUT - 1);
    localparam logic [31:0]       c_BASE      = 32'(BASE_ADDR);
    localparam logic [31:0]       c_LOCK_A    = c_BASE + 32'(NUM_REGS);
    localparam logic [31:0]       c_UNLOCK_A  = c_BASE + 32'(NUM_REGS) + 32'd1;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_lock;
    logic [7:0]          r_viol;
    logic [1:0]          r_state;
    logic [15:0]         r_timer;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic [1:0]          w_state_nxt;
    logic [15:0]         w_timer_nxt;
    logic                w_accept;
    logic [31:0]         w_addr_ext;
    logic                w_hit_reg;
    logic                w_hit_lock;
    logic                w_hit_unlock;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_err;
    logic                w_denied;
    logic                w_reg_we;
    logic                w_lock_we;
    logic                w_unlock_wr;
    logic                w_arm_match;
    logic                w_open_match;
    logic                w_arm_abort;
    logic                w_viol_evt;
    logic                w_zeroize;

    assign req_ready       = !r_rsp_valid || rsp_ready;
    assign w_accept        = req_valid && req_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;
    assign lock_status     = r_lock;
    assign violation_count = r_viol;
    assign debug_open      = (r_state == c_OPEN);

    // Address decode in a 32-bit space so addresses below the base never alias.
    assign w_addr_ext   = 32'(req_addr);
    assign w_hit_reg    = (w_addr_ext >= c_BASE) && (w_addr_ext < c_LOCK_A);
    assign w_hit_lock   = (w_addr_ext == c_LOCK_A);
    assign w_hit_unlock = (w_addr_ext == c_UNLOCK_A);
    assign w_idx        = IDX_W'(w_addr_ext - c_BASE);

    // Access permission and read-data selection.
    always_comb begin
        w_rdata     = '0;
        w_err       = 1'b0;
        w_denied    = 1'b0;
        w_reg_we    = 1'b0;
        w_lock_we   = 1'b0;
        w_unlock_wr = 1'b0;
        if (w_hit_reg) begin
            if (w_idx == '0) begin
                if (req_write) begin
                    if (req_priv >= 2'd2 && !r_lock[0]) w_reg_we = 1'b1;
                    else                                w_denied = 1'b1;
                end else if (req_priv == 2'd3 && r_state == c_OPEN) begin
                    w_rdata = r_regs[0];
                end else begin
                    w_denied = 1'b1;
                end
            end else begin
                if (req_write) begin
                    // Locks win over the debug window: no privilege bypasses them.
                    if (req_priv >= 2'd1 && !r_lock[w_idx]) w_reg_we = 1'b1;
                    else                                    w_denied = 1'b1;
                end else begin
                    w_rdata = r_regs[w_idx];
                end
            end
        end else if (w_hit_lock) begin
            if (req_write) begin
                if (req_priv >= 2'd2) w_lock_we = 1'b1;
                else                  w_denied  = 1'b1;
            end else begin
                w_rdata = DATA_W'(r_lock);
            end
        end else if (w_hit_unlock) begin
            if (req_write) begin
                // Any write closes an open window; otherwise debug privilege is needed.
                if (r_state == c_OPEN || req_priv == 2'd3) w_unlock_wr = 1'b1;
                else                                        w_denied    = 1'b1;
            end else begin
                w_rdata = DATA_W'(r_state);
            end
        end else begin
            w_err = 1'b1;
        end
        if (w_denied) w_err = 1'b1;
    end

    assign w_arm_match  = w_unlock_wr && (req_priv == 2'd3) && (req_wdata == c_ARM_CODE);
    assign w_open_match = w_unlock_wr && (req_priv == 2'd3) && (req_wdata == c_OPEN_CODE);
    // The unlock sequence must be strictly back-to-back; anything else aborts it.
    assign w_arm_abort  = w_accept && (r_state == c_ARMED) && !w_open_match;
    assign w_viol_evt   = (w_accept && w_denied) || w_arm_abort;

`ifdef SCR_ZEROIZE_EN
    assign w_zeroize = w_viol_evt && (r_viol == 8'd3);
`else
    assign w_zeroize = 1'b0;
`endif

    // Unlock FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            c_IDLE: begin
                if (w_accept && w_arm_match) w_state_nxt = c_ARMED;
            end
            c_ARMED: begin
                if (w_accept) begin
                    if (w_open_match) begin
                        w_state_nxt = c_OPEN;
                        w_timer_nxt = c_TMR_LOAD;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end
            c_OPEN: begin
                if ((w_accept && w_unlock_wr) || r_timer == 16'd0) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
        if (w_zeroize) w_state_nxt = c_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs[0] <= KEY_INIT;
            for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_lock      <= '0;
            r_viol      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_rdata;
                r_rsp_err   <= w_err;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_accept && w_reg_we)  r_regs[w_idx] <= req_wdata;
            if (w_accept && w_lock_we) r_lock <= r_lock | NUM_REGS'(req_wdata);
            if (w_viol_evt && r_viol != 8'hFF) r_viol <= r_viol + 8'd1;
            if (w_zeroize) begin
                r_regs[0] <= '0;
                r_lock[0] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
